pc_step_ctrl: RTL and testbench
===============================

# pc_step_ctrl

Program-counter step controller for the picoMIPS affine-transformation core. It sits directly upstream of the program counter and produces the `PCincr` qualifier that the counter adds to its current value every clock. It synchronises and debounces the external handshake switch. It holds the program counter on WAIT instructions until a full press-and-release of the switch, and freezes it permanently on HALT until reset.

## Interface
- `Osize`, default 3: width of the opcode field decoded from the current instruction.
- `DBcycles`, default 4: consecutive stable cycles required before the debounced switch level changes; legal range 1–255.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `sw_raw`  in  1  external handshake switch; asynchronous and may bounce.
- `opcode`  in  `Osize`  opcode of the instruction currently addressed by the program counter; combinational from program memory.
- `PCincr`  out  1  step qualifier to the program counter: 1 advances it by one, 0 holds it.
- `sw_clean`  out  1  synchronised, debounced switch level.
- `waiting`  out  1  high while a WAIT handshake is in progress.
- `halted`  out  1  high once HALT has been executed.

## Operation
- Synchroniser:
  - Two flip-flops on `sw_raw` produce `sw_sync`.
  - Both reset to 0.
- Debounce:
  - An 8-bit counter `db_cnt` increments on each edge where `sw_sync != sw_clean`.
  - Any edge with `sw_sync == sw_clean` clears `db_cnt`.
  - On the edge where `sw_sync` still differs and `db_cnt == DBcycles-1`: `sw_clean` toggles and `db_cnt` clears.
- FSM states: RUN, ARM_HI, ARM_LO, HALT. Reset state is RUN.
  - RUN, `opcode` is neither OP_WAIT nor OP_HALT: `PCincr` = 1; stay in RUN.
  - RUN, `opcode == OP_WAIT`: `PCincr` = 0; next state ARM_HI.
  - RUN, `opcode == OP_HALT`: `PCincr` = 0; next state HALT.
  - ARM_HI: `PCincr` = 0; if `sw_clean` = 1, go to ARM_LO. A switch already held when WAIT is reached counts as the press.
  - ARM_LO: `PCincr` = 0 while `sw_clean` = 1. When `sw_clean` = 0: `PCincr` = 1 in that same cycle and next state RUN, so the WAIT instruction retires on release.
  - HALT: `PCincr` = 0 permanently. Only `rst` exits this state.
- `PCincr` is combinational from state, `opcode` and `sw_clean`, and is forced to 0 while `rst` = 0.
- `waiting` = (state is ARM_HI or ARM_LO). `halted` = (state is HALT). Both are state decodes with no extra logic.
- Unknown opcodes are treated as ordinary instructions in RUN.
- Reset mid-handshake: the FSM returns to RUN, and the synchroniser, `db_cnt` and `sw_clean` all clear. Any switch press in progress is lost.

## Timing
- Reset values:
  - `PCincr` = 0 while `rst` is low.
  - `sw_clean` = 0, `waiting` = 0, `halted` = 0.
- Switch latency: a clean level change on `sw_raw` appears on `sw_clean` after exactly `DBcycles` + 2 rising edges, provided the level holds throughout.
- Glitches: any glitch shorter than `DBcycles` cycles (after synchronisation) is filtered out.
- WAIT retirement: `PCincr` pulses for exactly one cycle, in the cycle where `sw_clean` is first seen low in ARM_LO. The program counter therefore advances on that edge.
- No same-cycle chaining: two back-to-back WAIT instructions each require their own full press-and-release, because ARM_LO returns to RUN before the second WAIT is decoded.

## Configuration
- `PC_DEBOUNCE_EN` defined:
  - The debounce counter is built as described above.
- `PC_DEBOUNCE_EN` undefined:
  - `sw_clean` = `sw_sync` directly, and `db_cnt` is not instantiated.
  - Switch latency becomes 2 edges.
  - `DBcycles` is ignored.

## Structure
- Package `pc_ctrl_pkg`:
  - `OP_WAIT` = 3'b110 and `OP_HALT` = 3'b111.
  - `step_state_t` enum with the values RUN, ARM_HI, ARM_LO, HALT.
- Sub-module `sw_debounce`:
  - Contains the synchroniser plus the debounce counter and its `PC_DEBOUNCE_EN` gating.
  - Ports: `clk`, `rst`, `sw_raw`, `sw_clean`; parameter `DBcycles`.
- The FSM and the `PCincr` decode live in `pc_step_ctrl`.

## Test plan
- Reset and RUN:
  - Stimulus: hold `rst` = 0 with `opcode` = 3'b000; then release `rst` = 1.
  - Response: while in reset, `PCincr`, `sw_clean`, `waiting` and `halted` are all 0. After release, `PCincr` = 1 every cycle.
- Debounce:
  - Stimulus: `DBcycles` = 4; `sw_raw` pulses 0→1→0 for 3 cycles, then goes to 1 and holds.
  - Response: `sw_clean` ignores the 3-cycle pulse and rises exactly 6 edges after `sw_raw` goes to 1 and holds.
- WAIT handshake:
  - Stimulus: `opcode` = OP_WAIT; hold `sw_raw` = 1 for 10 cycles, then 0.
  - Response: `PCincr` = 0 and `waiting` = 1 throughout. `PCincr` is 1 for exactly one cycle, 6 edges after release, then returns to RUN.
- Pre-held switch:
  - Stimulus: `sw_clean` is already 1 when OP_WAIT arrives.
  - Response: the FSM goes RUN→ARM_HI→ARM_LO on consecutive edges, and `PCincr` stays 0 until release.
- HALT:
  - Stimulus: `opcode` = OP_HALT, then `opcode` = 3'b000 with switch activity.
  - Response: `halted` = 1 and `PCincr` = 0 indefinitely. Only `rst` = 0 clears it.
- Reset mid-handshake:
  - Stimulus: assert `rst` while in ARM_LO.
  - Response: the FSM is in RUN, `sw_clean` = 0 and `waiting` = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the picoMIPS program-counter step controller:
// special opcodes and the step FSM state type.
package pc_ctrl_pkg;

    // Opcodes that stall the program counter
    localparam logic [2:0] OP_WAIT = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // RUN    : PC advances on every ordinary instruction
    // ARM_HI : WAIT decoded, waiting for the switch to be pressed
    // ARM_LO : switch pressed, waiting for release to retire the WAIT
    // HALT   : frozen until reset
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        ARM_HI = 2'd1,
        ARM_LO = 2'd2,
        HALT   = 2'd3
    } step_state_t;

endpackage

// File: rtl/sw_debounce.sv
// Handshake switch conditioner: a two-flop synchroniser followed, when
// PC_DEBOUNCE_EN is defined, by a run-length debounce counter. Without
// PC_DEBOUNCE_EN the synchronised level is passed straight through and
// DBcycles has no effect.
module sw_debounce #(
    parameter int DBcycles = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic sw_clean
);

    logic sw_meta;
    logic sw_sync;

    // Two-stage synchroniser for the asynchronous switch input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta <= 1'b0;
            sw_sync <= 1'b0;
        end else begin
            sw_meta <= sw_raw;
            sw_sync <= sw_meta;
        end
    end

`ifdef PC_DEBOUNCE_EN
    // Counter reaches DbLast on the DBcycles-th consecutive differing sample
    localparam logic [7:0] DbLast = 8'(DBcycles - 1);

    logic [7:0] db_cnt;

    // Count consecutive samples that disagree with the clean level; flip the
    // clean level once the disagreement has lasted DBcycles edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db_cnt   <= 8'd0;
            sw_clean <= 1'b0;
        end else if (sw_sync == sw_clean) begin
            db_cnt <= 8'd0;
        end else if (db_cnt == DbLast) begin
            sw_clean <= ~sw_clean;
            db_cnt   <= 8'd0;
        end else begin
            db_cnt <= db_cnt + 8'd1;
        end
    end
`else
    // Debounce disabled: the parameter is kept only for interface
    // compatibility, so tie it off into a deliberately unused net
    logic db_param_unused;
    assign db_param_unused = (DBcycles > 0);

    assign sw_clean = sw_sync;
`endif

endmodule

// File: rtl/pc_step_ctrl.sv
// Program-counter step controller. Produces PCincr, the advance/hold
// qualifier for the program counter, holding it on WAIT until a full
// press-and-release of the handshake switch and freezing it on HALT.
// Optional feature macro: PC_DEBOUNCE_EN (enables the switch debouncer).
//
// Handshake: PCincr is a level qualifier, not a valid/ready pair. The PC
// adds PCincr on every rising clk edge; PCincr = 1 means "this instruction
// retires on the coming edge", PCincr = 0 means "hold the current address".
// The WAIT handshake is press (sw_clean 0->1) followed by release (1->0);
// the release cycle is the one in which the WAIT retires.
module pc_step_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int Osize    = 3,
    parameter int DBcycles = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sw_raw,
    input  logic [Osize-1:0] opcode,
    output logic             PCincr,
    output logic             sw_clean,
    output logic             waiting,
    output logic             halted,
    output step_state_t      state_dbg
);

    localparam logic [Osize-1:0] OpWait = Osize'(OP_WAIT);
    localparam logic [Osize-1:0] OpHalt = Osize'(OP_HALT);

    step_state_t state;
    step_state_t state_next;
    logic        step;

    sw_debounce #(
        .DBcycles (DBcycles)
    ) u_sw_debounce (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean)
    );

    // Step FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and step decode; unknown opcodes step like ordinary ones
    always_comb begin
        state_next = state;
        step       = 1'b0;
        case (state)
            RUN: begin
                if (opcode == OpWait) begin
                    state_next = ARM_HI;
                end else if (opcode == OpHalt) begin
                    state_next = HALT;
                end else begin
                    step = 1'b1;
                end
            end
            ARM_HI: begin
                // A switch already held when WAIT arrives counts as the press
                if (sw_clean) begin
                    state_next = ARM_LO;
                end
            end
            ARM_LO: begin
                // Release retires the WAIT in this same cycle
                if (!sw_clean) begin
                    step       = 1'b1;
                    state_next = RUN;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Reset masks the step so the PC cannot move while rst is low
    assign PCincr    = step & rst;
    assign waiting   = (state == ARM_HI) || (state == ARM_LO);
    assign halted    = (state == HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_pc_step_ctrl.sv
// Self-checking bench for pc_step_ctrl: directed phases (reset, debounce,
// WAIT handshake, pre-held switch, reset mid-handshake, HALT) plus a
// randomized stretch, all checked every cycle against a reference model.
module tb_pc_step_ctrl;
    import pc_ctrl_pkg::*;

    localparam int DB = 4;
`ifdef PC_DEBOUNCE_EN
    localparam int LAT = DB + 2;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_raw;
    logic [2:0]  opcode;
    logic        PCincr;
    logic        sw_clean;
    logic        waiting;
    logic        halted;
    step_state_t state_dbg;

    int tests = 0;
    int fails = 0;

    // Reference model
    step_state_t m_state;
    logic        m_s1, m_s2, m_clean;
    logic [0:0]  run_q[$];
    logic [0:0]  exp_q[$];

    int   rise, pulse, seg, r;
    logic raw_v;
    logic [2:0] op_v;

    // Clock
    always #5 clk = ~clk;

    pc_step_ctrl #(
        .Osize    (3),
        .DBcycles (DB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_raw    (sw_raw),
        .opcode    (opcode),
        .PCincr    (PCincr),
        .sw_clean  (sw_clean),
        .waiting   (waiting),
        .halted    (halted),
        .state_dbg (state_dbg)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = RUN;
        m_s1    = 1'b0;
        m_s2    = 1'b0;
        m_clean = 1'b0;
        run_q.delete();
    endtask

    // PC advances on ordinary instructions in RUN and on release in ARM_LO
    function automatic logic model_pc();
        if (!rst) return 1'b0;
        if (m_state == RUN)    return !(opcode == OP_WAIT || opcode == OP_HALT);
        if (m_state == ARM_LO) return !m_clean;
        return 1'b0;
    endfunction

    // Apply one rising edge to the model using the present inputs
    task automatic model_edge();
        logic s_old;
        case (m_state)
            RUN:    if (opcode == OP_WAIT) m_state = ARM_HI;
                    else if (opcode == OP_HALT) m_state = HALT;
            ARM_HI: if (m_clean) m_state = ARM_LO;
            ARM_LO: if (!m_clean) m_state = RUN;
            default: ;
        endcase
        s_old = m_s2;
        m_s2  = m_s1;
        m_s1  = sw_raw;
`ifdef PC_DEBOUNCE_EN
        // Clean level follows once DB consecutive synced samples disagree
        if (s_old == m_clean) begin
            run_q.delete();
        end else begin
            run_q.push_back(s_old);
            if (run_q.size() >= DB) begin
                m_clean = s_old;
                run_q.delete();
            end
        end
`else
        m_clean = m_s2;
`endif
    endtask

    // Driver: drive after the rising edge, check at the falling edge
    task automatic do_cycle(input logic rv, input logic raw, input logic [2:0] op);
        @(posedge clk);
        #1;
        rst    = rv;
        sw_raw = raw;
        opcode = op;
        @(negedge clk);
        if (!rst) model_reset();
        exp_q.push_back(model_pc());
        check("pcincr",   {7'd0, PCincr},   {7'd0, exp_q.pop_front()});
        check("sw_clean", {7'd0, sw_clean}, {7'd0, m_clean});
        check("waiting",  {7'd0, waiting},  {7'd0, (m_state == ARM_HI || m_state == ARM_LO)});
        check("halted",   {7'd0, halted},   {7'd0, (m_state == HALT)});
        check("state",    {6'd0, state_dbg}, {6'd0, m_state});
        if (rst) model_edge();
    endtask

    initial begin
        rst    = 1'b0;
        sw_raw = 1'b0;
        opcode = 3'b000;
        model_reset();

        // Reset then plain RUN
        repeat (3) do_cycle(1'b0, 1'b0, 3'b000);
        repeat (5) do_cycle(1'b1, 1'b0, 3'b000);

        // Debounce: short pulse, then a held press
        repeat (3) do_cycle(1'b1, 1'b1, 3'b000);
        repeat (3) do_cycle(1'b1, 1'b0, 3'b000);
        rise = -1;
        for (int i = 0; i < LAT + 4; i++) begin
            do_cycle(1'b1, 1'b1, 3'b000);
            if (sw_clean === 1'b1 && rise < 0) rise = i;
        end
        check("rise_latency", 8'(rise), 8'(LAT));
        repeat (LAT + 2) do_cycle(1'b1, 1'b0, 3'b000);

        // WAIT handshake: press, hold, release
        repeat (LAT + 4) do_cycle(1'b1, 1'b1, OP_WAIT);
        check("wait_armed", {7'd0, waiting}, 8'd1);
        pulse = -1;
        for (int i = 0; i < LAT + 4; i++) begin
            do_cycle(1'b1, 1'b0, (pulse >= 0) ? 3'b000 : OP_WAIT);
            if (pulse < 0 && PCincr === 1'b1) pulse = i;
        end
        check("retire_latency", 8'(pulse), 8'(LAT));

        // Pre-held switch: RUN -> ARM_HI -> ARM_LO on consecutive edges
        repeat (LAT + 2) do_cycle(1'b1, 1'b1, 3'b000);
        do_cycle(1'b1, 1'b1, OP_WAIT);
        check("pre_run", {6'd0, state_dbg}, {6'd0, RUN});
        do_cycle(1'b1, 1'b1, OP_WAIT);
        check("pre_arm_hi", {6'd0, state_dbg}, {6'd0, ARM_HI});
        do_cycle(1'b1, 1'b1, OP_WAIT);
        check("pre_arm_lo", {6'd0, state_dbg}, {6'd0, ARM_LO});
        repeat (2) do_cycle(1'b1, 1'b1, OP_WAIT);

        // Asynchronous reset mid-handshake, observed before any clock edge
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_state",    {6'd0, state_dbg}, {6'd0, RUN});
        check("async_sw_clean", {7'd0, sw_clean}, 8'd0);
        check("async_waiting",  {7'd0, waiting},  8'd0);
        check("async_pcincr",   {7'd0, PCincr},   8'd0);
        model_reset();
        do_cycle(1'b0, 1'b0, 3'b000);
        do_cycle(1'b1, 1'b0, 3'b000);

        // Randomized switch activity and instruction mix (no HALT)
        seg   = 0;
        raw_v = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (seg == 0) begin
                raw_v = ~raw_v;
                seg   = $urandom_range(1, 3 * DB);
            end
            seg--;
            r    = $urandom_range(0, 9);
            op_v = (r < 2) ? OP_WAIT : 3'($urandom_range(0, 5));
            do_cycle(1'b1, raw_v, op_v);
        end

        // HALT is permanent until reset
        do_cycle(1'b0, 1'b0, 3'b000);
        do_cycle(1'b1, 1'b0, 3'b000);
        do_cycle(1'b1, 1'b0, OP_HALT);
        do_cycle(1'b1, 1'b0, 3'b000);
        check("halt_entered", {7'd0, halted}, 8'd1);
        raw_v = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) raw_v = ~raw_v;
            do_cycle(1'b1, raw_v, 3'($urandom_range(0, 7)));
        end
        check("halt_held",        {7'd0, halted}, 8'd1);
        check("halt_pcincr_held", {7'd0, PCincr}, 8'd0);
        do_cycle(1'b0, 1'b0, 3'b000);
        check("halt_cleared", {7'd0, halted}, 8'd0);
        do_cycle(1'b1, 1'b0, 3'b000);
        check("run_after_halt", {7'd0, PCincr}, 8'd1);

        // Report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
